// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg : shared 7-segment glyph constants and digit types.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  localparam int DIGITS = 4;

  typedef logic [3:0] nibble_t;

  // Glyphs are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

endpackage

`default_nettype wire

// File: rtl/seg7_result_scan_if.sv
// ----------------------------------------------------------------------------
// seg7_result_scan_if : status word in, multiplexed display lines out.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface seg7_result_scan_if;
  logic [15:0] status;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [14:0] shown;

  modport master (output status, input an, input seg, input dp, input shown);
  modport slave  (input status, output an, output seg, output dp, output shown);
endinterface

`default_nettype wire

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode : combinational hex nibble to active-low 7-segment glyph.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] glyph
);

  assign glyph = SEG_GLYPH[nibble];

endmodule

`default_nettype wire

// File: rtl/seg7_result_scan.sv
// ----------------------------------------------------------------------------
// seg7_result_scan : latches the wrapper result and scans it onto a 4-digit
// common-anode display with a busy spinner. Option: SEG7_LEADING_ZERO_BLANK_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_result_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_BITS  = 16,
  parameter int SPIN_SCANS = 8
) (
  input  logic               clk,
  input  logic               nrst,
  seg7_result_scan_if.slave  bus
);

  localparam int RW = (SPIN_SCANS > 1) ? $clog2(SPIN_SCANS) : 1;
  localparam logic [SCAN_BITS-1:0] DIV_ONE   = 1;
  localparam logic [RW-1:0]        ROUND_ONE = 1;
  localparam logic [RW-1:0]        ROUND_TOP = RW'(SPIN_SCANS - 1);

  logic [SCAN_BITS-1:0] div_q, div_d;
  logic [1:0]           idx_q, idx_d;
  logic [RW-1:0]        round_q, round_d;
  logic [1:0]           spin_q, spin_d;
  logic                 busy_q, busy_d;
  logic [14:0]          latch_q, latch_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic        busy_in;
  logic        div_wrap;
  logic        round_done;
  logic        spin_step;
  logic        blank;
  logic [15:0] value;
  nibble_t     nib;
  logic [6:0]  glyph;

  seg7_decode u_decode (
    .nibble (nib),
    .glyph  (glyph)
  );

  always_comb begin
    busy_in    = bus.status[15];
    busy_d     = busy_in;

    // Falling busy edge, or an idle result that changed without a busy pulse.
    latch_d = latch_q;
    if (!busy_in && (busy_q || (bus.status[14:0] != latch_q))) begin
      latch_d = bus.status[14:0];
    end

    div_d      = div_q + DIV_ONE;
    div_wrap   = &div_q;
    idx_d      = div_wrap ? idx_q + 2'd1 : idx_q;
    round_done = div_wrap && (idx_q == 2'd3);
    spin_step  = round_done && (round_q == ROUND_TOP);

    round_d = round_q;
    if (spin_step) begin
      round_d = '0;
    end else if (round_done) begin
      round_d = round_q + ROUND_ONE;
    end

    // A busy fall on a step cycle clears rather than advances.
    spin_d = spin_q;
    if (!busy_q || !busy_in) begin
      spin_d = 2'd0;
    end else if (spin_step) begin
      spin_d = spin_q + 2'd1;
    end

    value = {1'b0, latch_q};
    nib   = nibble_t'(value >> {idx_q, 2'b00});

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (idx_q != 2'd0) && ((value >> {idx_q, 2'b00}) == 16'd0);
`else
    blank = 1'b0;
`endif

    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : glyph;
    dp_d  = !(busy_q && (idx_q == spin_q));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_q   <= '0;
      idx_q   <= 2'd0;
      round_q <= '0;
      spin_q  <= 2'd0;
      busy_q  <= 1'b0;
      latch_q <= 15'd0;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      spin_q  <= spin_d;
      busy_q  <= busy_d;
      latch_q <= latch_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.shown = latch_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_result_scan.sv
// ----------------------------------------------------------------------------
// tb_seg7_result_scan : randomized bench for seg7_result_scan against a
// time-indexed reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg7_result_scan;

  localparam int SB = 2;
  localparam int SS = 2;
  localparam int ROUND_CLKS = 4 << SB;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  seg7_result_scan_if bus ();

  seg7_result_scan #(
    .SCAN_BITS  (SB),
    .SPIN_SCANS (SS)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: clocks since reset, latched result, previous busy, spinner.
  int          m_t;
  logic [14:0] m_latch;
  logic        m_busy;
  int          m_spin;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic model_reset();
    m_t     = 0;
    m_latch = 15'd0;
    m_busy  = 1'b0;
    m_spin  = 0;
  endtask

  task automatic model_edge(input logic [15:0] s);
    int d, v, nib, nxt;
    bit step;
    logic [3:0] one4;
    one4  = 4'b0001;
    d     = (m_t >> SB) % 4;
    v     = int'(m_latch);
    nib   = (v >> (4 * d)) & 15;
    e_an  = ~(one4 << d);
    e_seg = glyphs[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 0) e_seg = 7'h7F;
`endif
    e_dp  = !(m_busy && d == m_spin);
    nxt   = m_t + 1;
    step  = (nxt % ROUND_CLKS == 0) && ((nxt / ROUND_CLKS) % SS == 0);
    if (!s[15] || !m_busy) m_spin = 0;
    else if (step)         m_spin = (m_spin + 1) % 4;
    if (!s[15]) m_latch = s[14:0];
    m_busy = s[15];
    m_t    = nxt;
  endtask

  task automatic cycle(input logic [15:0] s);
    bus.status = s;
    @(posedge clk);
    model_edge(s);
    @(negedge clk);
    chk("an",     {28'd0, bus.an},     {28'd0, e_an});
    chk("seg",    {25'd0, bus.seg},    {25'd0, e_seg});
    chk("dp",     {31'd0, bus.dp},     {31'd0, e_dp});
    chk("shown",  {17'd0, bus.shown},  {17'd0, m_latch});
    chk("an_one", $countones(~bus.an), 32'd1);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"},    {28'd0, bus.an},    32'hF);
    chk({tag, "_seg"},   {25'd0, bus.seg},   32'h7F);
    chk({tag, "_dp"},    {31'd0, bus.dp},    32'h1);
    chk({tag, "_shown"}, {17'd0, bus.shown}, 32'h0);
  endtask

  initial begin
    int k;
    bus.status = 16'h1234;
    nrst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_blank("reset");

    #2 nrst = 1'b1;
    cycle(16'h1234);
    chk("first_an", {28'd0, bus.an}, 32'hE);
    chk("first_seg", {25'd0, bus.seg}, 32'h40);
    cycle(16'h1234);

    cycle(16'h0ABC);
    chk("idle_load", {17'd0, bus.shown}, 32'h0ABC);
    repeat (16) cycle(16'h0ABC);

    repeat (4) cycle(16'h0005);
    repeat (100) cycle(16'h8123);
    chk("busy_hold", {17'd0, bus.shown}, 32'h0005);
    cycle(16'h0123);
    chk("busy_fall", {17'd0, bus.shown}, 32'h0123);
    repeat (20) cycle(16'h0123);

    k = 0;
    while (bus.an != 4'hB && k < 40) begin
      cycle(16'h0123);
      k++;
    end
    chk("seek_anB", {28'd0, bus.an}, 32'hB);
    #2 nrst = 1'b0;
    #1 chk_blank("async_rst");
    #1 nrst = 1'b1;
    model_reset();
    cycle(16'h0123);
    chk("restart_an", {28'd0, bus.an}, 32'hE);

    repeat (20) cycle(16'h0007);
    repeat (20) cycle(16'h0000);

    // Random segments: idle runs with a steady value, busy runs with noise.
    repeat (30) begin
      bit          b;
      int          len;
      logic [14:0] r;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 90);
      r   = ($urandom_range(0, 2) == 0) ? 15'($urandom_range(0, 15)) : 15'($urandom);
      for (int i = 0; i < len; i++) begin
        if (b) cycle({1'b1, 15'($urandom)});
        else   cycle({1'b0, r});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_result_scan.md
Name: seg7_result_scan

Overview:
- Downstream display stage for the Collatz switch/button board test wrapper.
- Consumes the wrapper's 16-bit status word {busy, result[14:0]} and drives a 4-digit multiplexed, common-anode 7-segment display.
- Holds the last completed result steady while a computation runs, and shows a rotating decimal-point spinner while busy is high.

Parameters:
- SCAN_BITS, 16: width of the refresh divider; the digit advances every 2^SCAN_BITS clocks.
- SPIN_SCANS, 8: number of full 4-digit scan rounds per spinner step while busy.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- status  in  16  {busy, result[14:0]} from the test wrapper output.
- an  out  4  digit enables, active-low; an[0] is the least significant digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- shown  out  15  currently latched result, for debug/LEDs.

Behaviour:
- Reset is asynchronous and active-low. While nrst=0:
  - an=4'hF, seg=7'h7F, dp=1, shown=0.
  - Divider=0, digit index=0, spinner=0, scan-round counter=0, busy_q=0.
- Input capture:
  - busy_q <= status[15] every clock.
  - The latch is loaded with status[14:0] on a falling busy edge: busy_q=1 and status[15]=0.
  - The latch is also loaded when status[15]=0 and status[14:0] differs from the latch. This covers an idle wrapper whose result changes without a busy pulse.
  - While status[15]=1 the latch holds and shown holds.
- Displayed value: {1'b0, latch} as 4 hex nibbles. Digit index k shows nibble k.
- Refresh divider:
  - SCAN_BITS-bit free-running counter, wrapping to 0.
  - On wrap, digit index advances 0->1->2->3->0.
  - On the index 3->0 wrap, the scan-round counter increments.
  - When the scan-round counter reaches SPIN_SCANS-1 it clears and the spinner advances (2-bit, wraps 3->0), but only if busy_q=1.
- Spinner on busy edges:
  - When busy_q is 0, the spinner is cleared to 0.
  - On a rising busy edge, the spinner starts from 0.
- Outputs are registered, one clock after the digit index or latch updates:
  - an = ~(4'b0001 << index).
  - seg = decode(nibble[index]).
  - dp = 0 iff busy_q=1 and index==spinner; else 1.
- Decoder: standard hex glyphs 0-9, A, b, C, d, E, F. Active-low, g is the MSB. Example: 0 -> 7'h40, 1 -> 7'h79, F -> 7'h0E.
- Simultaneous events:
  - A latch update on the same clock as a digit advance: the new value is shown from the next registered output.
  - A busy fall on the same clock as a spinner step: the spinner clears (the clear wins).
- Reset mid-scan: all outputs blank immediately (asynchronous). Scanning resumes from digit 0 on the first clock after nrst rises.
- Ghosting: no two an bits are ever low in the same cycle.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit k>0 is blanked (seg=7'h7F; an still driven) when all nibbles with index >= k are 0.
  - Digit 0 is never blanked.
  - dp spinner behaviour is unchanged.
- Undefined: all four digits always show, including leading zeros.

Decomposition:
- Shared package seg7_pkg:
  - Segment glyph constants SEG_BLANK=7'h7F and the 16 hex glyphs.
  - A digit-count constant of 4.
  - A nibble type of 4 bits.
- One natural sub-module, seg7_decode: combinational nibble->glyph, reused by other board-test wrappers.
- The scan, latch and spinner logic stays in seg7_result_scan.

Test Plan (simulate with SCAN_BITS=2, SPIN_SCANS=2):
- Reset: hold nrst=0 and drive status=16'h1234 -> an=F, seg=7F, dp=1, shown=0. Release nrst -> first an=E within 2 clocks, with seg=decode(0).
- Idle load: status=16'h0ABC -> shown=15'h0ABC next clock. Over 16 clocks an cycles E,D,B,7 with seg C,B,A,0 glyphs (0x46,0x03,0x08,0x40); dp stays 1.
- Busy hold: status=16'h0005, then status=16'h8123 for 100 clocks -> shown stays 5 and digit 0 shows 0x12. dp=0 on digit 0 first, then on digits 1,2,3,0 in turn, each step lasting 32 clocks.
- Busy fall: status goes 16'h8123 -> 16'h0123 -> shown=15'h0123 one clock later; dp returns to 1 and the spinner resets to 0.
- Asynchronous reset mid-scan: pulse nrst low mid-clock while an=B -> an=F immediately with no clock edge; after release, scan restarts at an=E.
- With SEG7_LEADING_ZERO_BLANK_EN: status=16'h0007 -> digits 1-3 give seg=7F, digit 0 gives 0x78. With status=16'h0000, digit 0 shows 0x40.
